data_stack: RTL and testbench

Operand LIFO that answers the controller's data-stack command interface. It latches operands on `SC_PUS`, drops the top on `SC_POP`, and empties on `SC_CLR`. It drives the shared tristate data bus with the current top whenever the controller is not pushing. It sits between the controller's data-stack port and the ALU operand path, and supplies `dt_empty` back to the controller.

---
 rtl/data_stack_pkg.sv | 11 +
 rtl/data_stack_lifo_ram.sv | 23 ++
 rtl/data_stack.sv | 100 ++++++++++
 tb/tb_data_stack.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared constants for the data-stack command interface and CPU-internal data path.
package data_stack_pkg;
  localparam int SC_N = 2;
  localparam logic [SC_N-1:0] SC_NON = 2'd0;
  localparam logic [SC_N-1:0] SC_PUS = 2'd1;
  localparam logic [SC_N-1:0] SC_POP = 2'd2;
  localparam logic [SC_N-1:0] SC_CLR = 2'd3;

  localparam int CD_N = 16;
  localparam logic [CD_N-1:0] CD_0 = 16'h0000;
endpackage

// File: rtl/data_stack_lifo_ram.sv
// Unreset LIFO storage: synchronous write port, asynchronous read port.
module lifo_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/data_stack.sv
// Operand LIFO on the controller's data-stack port; drives the shared bus with the top
// entry whenever the controller is not pushing.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [SC_N-1:0] dt_cmd,
  inout  wire  [CD_N-1:0] dt_data,
  output logic            dt_empty,
  output logic            dt_full,
  output logic [AW:0]     dt_count,
  output logic            dt_ovf,
  output logic            dt_unf
);
  logic [AW:0]     ptr_q, ptr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            we_s;
  logic            empty_s;
  logic            full_s;
  logic [CD_N-1:0] rdata_s;
  logic [CD_N-1:0] top_s;
  logic            drive_s;

  assign empty_s = (ptr_q == (AW+1)'(0));
  assign full_s  = (ptr_q == (AW+1)'(DEPTH));

  // Command decode; the full/empty guards keep ptr from ever wrapping.
  always_comb begin
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we_s  = 1'b0;
    case (dt_cmd)
      SC_PUS: begin
        if (full_s) begin
          ovf_d = 1'b1;
        end else begin
          we_s  = 1'b1;
          ptr_d = ptr_q + (AW+1)'(1);
        end
      end
      SC_POP: begin
        if (empty_s) begin
          unf_d = 1'b1;
        end else begin
          ptr_d = ptr_q - (AW+1)'(1);
        end
      end
      SC_CLR: begin
        ptr_d = (AW+1)'(0);
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      default: begin
        ptr_d = ptr_q;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr_q <= (AW+1)'(0);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  lifo_ram #(
    .DEPTH(DEPTH),
    .W    (CD_N),
    .AW   (AW)
  ) u_ram (
    .clk  (Clock),
    .we   (we_s & ~Reset),
    .waddr(ptr_q[AW-1:0]),
    .wdata(dt_data),
    .raddr(ptr_q[AW-1:0] - AW'(1)),
    .rdata(rdata_s)
  );

  // Bus released during pushes so the controller owns it without contention.
  assign top_s   = empty_s ? CD_0 : rdata_s;
  assign drive_s = ~Reset && (dt_cmd != SC_PUS);
  assign dt_data = drive_s ? top_s : {CD_N{1'bz}};

  assign dt_empty = empty_s;
  assign dt_full  = full_s;
  assign dt_count = ptr_q;
  assign dt_ovf   = ovf_q;
  assign dt_unf   = unf_q;
endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: vector table plus fill/overflow and reset sequences.
module tb_data_stack;
  import data_stack_pkg::*;

  logic            Clock;
  logic            Reset;
  logic [SC_N-1:0] dt_cmd;
  wire  [CD_N-1:0] dt_data;
  logic            dt_empty;
  logic            dt_full;
  logic [4:0]      dt_count;
  logic            dt_ovf;
  logic            dt_unf;
  logic            tb_oe;
  logic [CD_N-1:0] tb_val;

  int n_cmp = 0;
  int n_bad = 0;

  assign dt_data = tb_oe ? tb_val : {CD_N{1'bz}};

  data_stack #(.DEPTH(16), .AW(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .dt_cmd  (dt_cmd),
    .dt_data (dt_data),
    .dt_empty(dt_empty),
    .dt_full (dt_full),
    .dt_count(dt_count),
    .dt_ovf  (dt_ovf),
    .dt_unf  (dt_unf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] din;
    logic [15:0] exp_bus;
    logic [4:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] cmd, input logic [15:0] din, input logic rst);
    @(negedge Clock);
    dt_cmd = cmd;
    Reset  = rst;
    tb_oe  = (cmd == SC_PUS);
    tb_val = din;
    #1;
  endtask

  task automatic post_edge;
    @(posedge Clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [15:0] d, input logic [15:0] b,
                              input logic [4:0] n, input logic o, input logic u);
    vec_t v;
    v.cmd = c; v.din = d; v.exp_bus = b; v.exp_cnt = n; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(SC_NON, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
    vecs[1]  = mk(SC_PUS, 16'd5, 16'd5, 5'd1, 1'b0, 1'b0);
    vecs[2]  = mk(SC_PUS, 16'd9, 16'd9, 5'd2, 1'b0, 1'b0);
    vecs[3]  = mk(SC_NON, 16'd0, 16'd9, 5'd2, 1'b0, 1'b0);
    vecs[4]  = mk(SC_POP, 16'd0, 16'd9, 5'd1, 1'b0, 1'b0);
    vecs[5]  = mk(SC_NON, 16'd0, 16'd5, 5'd1, 1'b0, 1'b0);
    vecs[6]  = mk(SC_POP, 16'd0, 16'd5, 5'd0, 1'b0, 1'b0);
    vecs[7]  = mk(SC_POP, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);
    vecs[8]  = mk(SC_NON, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);
    vecs[9]  = mk(SC_CLR, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
    vecs[10] = mk(SC_PUS, 16'd3, 16'd3, 5'd1, 1'b0, 1'b0);
    vecs[11] = mk(SC_PUS, 16'd4, 16'd4, 5'd2, 1'b0, 1'b0);
    vecs[12] = mk(SC_CLR, 16'd0, 16'd4, 5'd0, 1'b0, 1'b0);
    vecs[13] = mk(SC_NON, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
    vecs[14] = mk(SC_PUS, 16'd7, 16'd7, 5'd1, 1'b0, 1'b0);
    vecs[15] = mk(SC_NON, 16'd0, 16'd7, 5'd1, 1'b0, 1'b0);
    vecs[16] = mk(SC_POP, 16'd0, 16'd7, 5'd0, 1'b0, 1'b0);

    Reset = 1'b1; dt_cmd = SC_NON; tb_oe = 1'b0; tb_val = 16'd0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_count", 32'(dt_count), 32'd0);
    chk("reset_empty", 32'(dt_empty), 32'd1);
    chk("reset_ovf",   32'(dt_ovf),   32'd0);
    chk("reset_unf",   32'(dt_unf),   32'd0);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].cmd, vecs[i].din, 1'b0);
      chk($sformatf("vec%0d_bus", i), 32'(dt_data), 32'(vecs[i].exp_bus));
      post_edge();
      chk($sformatf("vec%0d_count", i), 32'(dt_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(dt_empty), 32'(vecs[i].exp_cnt == 5'd0));
      chk($sformatf("vec%0d_full", i),  32'(dt_full),  32'(vecs[i].exp_cnt == 5'd16));
      chk($sformatf("vec%0d_ovf", i),   32'(dt_ovf),   32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i),   32'(dt_unf),   32'(vecs[i].exp_unf));
    end

    // Fill to capacity, overflow, then drain in LIFO order.
    for (int i = 1; i <= 16; i++) begin
      step(SC_PUS, 16'(i), 1'b0);
      chk("fill_bus", 32'(dt_data), 32'(i));
      post_edge();
      chk("fill_count", 32'(dt_count), 32'(i));
    end
    chk("fill_full", 32'(dt_full), 32'd1);
    chk("fill_ovf_clear", 32'(dt_ovf), 32'd0);
    step(SC_PUS, 16'd99, 1'b0);
    post_edge();
    chk("ovf_set", 32'(dt_ovf), 32'd1);
    chk("ovf_count", 32'(dt_count), 32'd16);
    step(SC_NON, 16'd0, 1'b0);
    chk("ovf_top", 32'(dt_data), 32'd16);
    post_edge();
    for (int i = 16; i >= 1; i--) begin
      step(SC_POP, 16'd0, 1'b0);
      chk("drain_bus", 32'(dt_data), 32'(i));
      post_edge();
      chk("drain_count", 32'(dt_count), 32'(i - 1));
    end
    chk("drain_empty", 32'(dt_empty), 32'd1);
    chk("drain_ovf_sticky", 32'(dt_ovf), 32'd1);
    step(SC_CLR, 16'd0, 1'b0);
    post_edge();
    chk("clr_ovf", 32'(dt_ovf), 32'd0);

    // Reset mid-sequence, coinciding with a push of 42.
    step(SC_PUS, 16'd11, 1'b0);
    post_edge();
    step(SC_PUS, 16'd12, 1'b0);
    post_edge();
    step(SC_PUS, 16'd42, 1'b1);
    chk("rst_push_bus", 32'(dt_data), 32'd42);
    post_edge();
    step(SC_NON, 16'd0, 1'b0);
    chk("rst_bus", 32'(dt_data), 32'd0);
    post_edge();
    chk("rst_count", 32'(dt_count), 32'd0);
    chk("rst_empty", 32'(dt_empty), 32'd1);
    step(SC_POP, 16'd0, 1'b0);
    chk("rst_pop_bus", 32'(dt_data), 32'd0);
    post_edge();
    chk("rst_pop_unf", 32'(dt_unf), 32'd1);
    chk("rst_pop_count", 32'(dt_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
